// File: rtl/io_hub.sv
// ---------------------------------------------------------------------------
// io_hub - parametrised CPU-bus to peripheral-channel hub.
//
// Connects the CPU main bus to NUM_DEV peripheral channels. The CPU first
// latches a device address (plus a register-select bit) from the bus. It
// then issues a write or a read strobe. The hub holds the selected device's
// strobe until that device acknowledges (dev_ready) or a timeout expires.
// The CPU is stalled through cpu_wait meanwhile, so slow peripherals need no
// clock-gated enables.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        synchronous, active-low reset
//   main_bus     CPU data bus; driven by the hub only during read completion
//   load_addr_n  active-low: latch {dev_rs, addr} from main_bus (IDLE only)
//   to_dev_n     active-low: CPU write to the selected device
//   from_dev_n   active-low: CPU read from the selected device
//   cpu_wait     high while the CPU must hold its current microstep
//   dev_sel_n    one-cold device select, valid during a transfer
//   dev_rs       register-select bit to the devices
//   dev_wr       write strobe, held until acknowledge or timeout
//   dev_rd       read strobe, held until acknowledge or timeout
//   dev_wdata    write data register
//   dev_rdata    flattened read data, device i at [i*DATA_W +: DATA_W]
//   dev_ready    per-device acknowledge
//
// Optional feature macro: IO_HUB_STATUS_EN
//   When defined, the address that is all ones with dev_rs=1 selects an
//   internal status register instead of a device. Reading it returns
//   {err, busy_seen, addr} with err in the MSB, busy_seen below it and addr
//   in the low bits. Both reading and writing it clear err. When undefined,
//   that address is an ordinary device and err is cleared only by reset.
// ---------------------------------------------------------------------------
module io_hub #(
    parameter  int DATA_W     = 8,
    parameter  int DEV_ADDR_W = 3,
    parameter  int TIMEOUT    = 16,
    localparam int NUM_DEV    = 2 ** DEV_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    inout  wire  [DATA_W-1:0]         main_bus,
    input  logic                      load_addr_n,
    input  logic                      to_dev_n,
    input  logic                      from_dev_n,
    output logic                      cpu_wait,
    output logic [NUM_DEV-1:0]        dev_sel_n,
    output logic                      dev_rs,
    output logic                      dev_wr,
    output logic                      dev_rd,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata,
    input  logic [NUM_DEV-1:0]        dev_ready
);

    // The timer only has to count up to TIMEOUT-1.
    localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic [DEV_ADDR_W-1:0]   addr_q,    addr_d;
    logic                    rs_q,      rs_d;
    logic [DATA_W-1:0]       wdata_q,   wdata_d;
    logic [DATA_W-1:0]       rd_buf_q,  rd_buf_d;
    logic                    err_q,     err_d;
    logic [TIMER_W-1:0]      timer_q,   timer_d;
    // Remembers whether the access now in DONE was a read; this decides
    // whether the bus may be driven. A protocol error counts as "not a read".
    logic                    last_rd_q, last_rd_d;

    logic                    busy_s;
    logic                    fwd_s;
    logic                    sel_ready_s;
    logic [DATA_W-1:0]       sel_rdata_s;
    logic                    drive_bus_s;

`ifdef IO_HUB_STATUS_EN
    // stat_q marks that the transfer in progress targets the status register.
    logic                    stat_q,      stat_d;
    // busy_seen: a device transfer has had to wait at least one edge for its
    // acknowledge since the status register was last read.
    logic                    busy_seen_q, busy_seen_d;
    logic                    stat_hit_s;
    logic [DATA_W-1:0]       stat_word_s;
`endif

    assign busy_s      = (state_q == WR_BUSY) || (state_q == RD_BUSY);
    assign sel_ready_s = dev_ready[addr_q];
    assign sel_rdata_s = dev_rdata[int'(addr_q) * DATA_W +: DATA_W];

`ifdef IO_HUB_STATUS_EN
    assign stat_hit_s = (&addr_q) && rs_q;
    assign fwd_s      = busy_s && !stat_q;

    // Status word: err in the MSB, busy_seen below it, address in the low bits.
    always_comb begin
        stat_word_s                   = '0;
        stat_word_s[DATA_W-1]         = err_q;
        stat_word_s[DATA_W-2]         = busy_seen_q;
        stat_word_s[DEV_ADDR_W-1:0]   = addr_q;
    end
`else
    assign fwd_s = busy_s;
`endif

    // Next-state logic for the transfer FSM and all datapath registers.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rs_d      = rs_q;
        wdata_d   = wdata_q;
        rd_buf_d  = rd_buf_q;
        err_d     = err_q;
        timer_d   = timer_q;
        last_rd_d = last_rd_q;
`ifdef IO_HUB_STATUS_EN
        stat_d      = stat_q;
        busy_seen_d = busy_seen_q;
`endif

        case (state_q)
            IDLE: begin
                // Address load takes priority over a transfer strobe on the same edge.
                if (!load_addr_n) begin
                    addr_d = main_bus[DEV_ADDR_W-1:0];
                    rs_d   = main_bus[DEV_ADDR_W];
                end else if (!to_dev_n && !from_dev_n) begin
                    err_d     = 1'b1;
                    last_rd_d = 1'b0;
                    state_d   = DONE;
                end else if (!to_dev_n) begin
                    last_rd_d = 1'b0;
                    timer_d   = '0;
                    state_d   = WR_BUSY;
`ifdef IO_HUB_STATUS_EN
                    stat_d = stat_hit_s;
                    // Data written to the status register is discarded.
                    if (!stat_hit_s) begin
                        wdata_d = main_bus;
                    end else begin
                        wdata_d = wdata_q;
                    end
`else
                    wdata_d = main_bus;
`endif
                end else if (!from_dev_n) begin
                    last_rd_d = 1'b1;
                    timer_d   = '0;
                    state_d   = RD_BUSY;
`ifdef IO_HUB_STATUS_EN
                    stat_d = stat_hit_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            WR_BUSY, RD_BUSY: begin
`ifdef IO_HUB_STATUS_EN
                // The status register answers on the first busy edge.
                if (stat_q) begin
                    state_d = DONE;
                    timer_d = '0;
                    err_d   = 1'b0;
                    stat_d  = 1'b0;
                    if (state_q == RD_BUSY) begin
                        rd_buf_d    = stat_word_s;
                        busy_seen_d = 1'b0;
                    end else begin
                        rd_buf_d = rd_buf_q;
                    end
                end else
`endif
                if (sel_ready_s) begin
                    state_d = DONE;
                    timer_d = '0;
                    if (state_q == RD_BUSY) begin
                        rd_buf_d = sel_rdata_s;
                    end else begin
                        rd_buf_d = rd_buf_q;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // Abort: a timed-out read returns all ones to the CPU.
                    state_d = DONE;
                    timer_d = '0;
                    err_d   = 1'b1;
                    if (state_q == RD_BUSY) begin
                        rd_buf_d = '1;
                    end else begin
                        rd_buf_d = rd_buf_q;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
`ifdef IO_HUB_STATUS_EN
                    busy_seen_d = 1'b1;
`endif
                end
            end

            DONE: begin
                timer_d = '0;
                // One access per strobe assertion: wait for both strobes to rise.
                if (to_dev_n && from_dev_n) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rs_q      <= 1'b0;
            wdata_q   <= '0;
            rd_buf_q  <= '0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            last_rd_q <= 1'b0;
`ifdef IO_HUB_STATUS_EN
            stat_q      <= 1'b0;
            busy_seen_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rs_q      <= rs_d;
            wdata_q   <= wdata_d;
            rd_buf_q  <= rd_buf_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            last_rd_q <= last_rd_d;
`ifdef IO_HUB_STATUS_EN
            stat_q      <= stat_d;
            busy_seen_q <= busy_seen_d;
`endif
        end
    end

    // Device-side outputs decoded from the state registers.
    always_comb begin
        dev_sel_n = '1;
        dev_wr    = 1'b0;
        dev_rd    = 1'b0;
        if (fwd_s) begin
            dev_sel_n = ~(NUM_DEV'(1) << addr_q);
            dev_wr    = (state_q == WR_BUSY);
            dev_rd    = (state_q == RD_BUSY);
        end else begin
            dev_sel_n = '1;
        end
    end

    assign dev_rs    = rs_q;
    assign dev_wdata = wdata_q;

    // CPU stall: busy states, or IDLE while a transfer strobe is pending.
    assign cpu_wait = busy_s ||
                      ((state_q == IDLE) && (!to_dev_n || !from_dev_n));

    assign drive_bus_s = (state_q == DONE) && !from_dev_n && last_rd_q;
    assign main_bus    = drive_bus_s ? rd_buf_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_io_hub.sv
// Directed, table-driven bench for io_hub (default parameters).
module tb_io_hub;

    logic        clk;
    logic        reset;
    logic        load_addr_n;
    logic        to_dev_n;
    logic        from_dev_n;
    logic        cpu_wait;
    logic [7:0]  dev_sel_n;
    logic        dev_rs;
    logic        dev_wr;
    logic        dev_rd;
    logic [7:0]  dev_wdata;
    logic [63:0] dev_rdata;
    logic [7:0]  dev_ready;
    wire  [7:0]  main_bus;
    logic [7:0]  bus_drv;
    logic        bus_en;

    int n_tests = 0;
    int n_fail  = 0;

    // When the hub must not drive, the bench drives a known pattern and
    // expects to read that pattern back unchanged.
    assign main_bus = bus_en ? bus_drv : 8'hzz;

    io_hub dut (
        .clk         (clk),
        .reset       (reset),
        .main_bus    (main_bus),
        .load_addr_n (load_addr_n),
        .to_dev_n    (to_dev_n),
        .from_dev_n  (from_dev_n),
        .cpu_wait    (cpu_wait),
        .dev_sel_n   (dev_sel_n),
        .dev_rs      (dev_rs),
        .dev_wr      (dev_wr),
        .dev_rd      (dev_rd),
        .dev_wdata   (dev_wdata),
        .dev_rdata   (dev_rdata),
        .dev_ready   (dev_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic       wr;
        logic       rd;
        logic [7:0] bus;
        logic       rel;
        logic [7:0] rdy;
        logic       e_wait;
        logic [7:0] e_sel;
        logic       e_wr;
        logic       e_rd;
        logic       e_rs;
        logic [7:0] e_wdata;
        logic [7:0] e_bus;
    } vec_t;

    vec_t vec [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic ld, input logic wr, input logic rd,
                         input logic [7:0] bus, input logic rel, input logic [7:0] rdy);
        reset       = rst;
        load_addr_n = ld;
        to_dev_n    = wr;
        from_dev_n  = rd;
        bus_drv     = bus;
        bus_en      = !rel;
        dev_ready   = rdy;
    endtask

    initial begin
        // Device i returns 0x10+i, except device 5 which returns 0x3C.
        for (int i = 0; i < 8; i++) begin
            dev_rdata[i*8 +: 8] = 8'h10 + 8'(i);
        end
        dev_rdata[5*8 +: 8] = 8'h3C;

        //            rst  ld   wr   rd   bus    rel  rdy      wait sel    wr   rd   rs   wdata  bus
        vec[0]  = '{1'b0,1'b1,1'b1,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'h00,8'h66};
        vec[1]  = '{1'b0,1'b1,1'b1,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'h00,8'h66};
        vec[2]  = '{1'b1,1'b0,1'b1,1'b1,8'h03,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'h00,8'h03};
        vec[3]  = '{1'b1,1'b1,1'b0,1'b1,8'hA5,1'b0,8'h00,  1'b1,8'hF7,1'b1,1'b0,1'b0,8'hA5,8'hA5};
        vec[4]  = '{1'b1,1'b1,1'b0,1'b1,8'h66,1'b0,8'h00,  1'b1,8'hF7,1'b1,1'b0,1'b0,8'hA5,8'h66};
        vec[5]  = '{1'b1,1'b1,1'b0,1'b1,8'h66,1'b0,8'h00,  1'b1,8'hF7,1'b1,1'b0,1'b0,8'hA5,8'h66};
        vec[6]  = '{1'b1,1'b1,1'b0,1'b1,8'h66,1'b0,8'h08,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h66};
        vec[7]  = '{1'b1,1'b1,1'b0,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h66};
        vec[8]  = '{1'b1,1'b1,1'b0,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h66};
        vec[9]  = '{1'b1,1'b1,1'b1,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h66};
        vec[10] = '{1'b1,1'b0,1'b0,1'b1,8'h05,1'b0,8'h00,  1'b1,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h05};
        vec[11] = '{1'b1,1'b1,1'b1,1'b0,8'h66,1'b0,8'h20,  1'b1,8'hDF,1'b0,1'b1,1'b0,8'hA5,8'h66};
        vec[12] = '{1'b1,1'b1,1'b1,1'b0,8'h00,1'b1,8'h20,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h3C};
        vec[13] = '{1'b1,1'b1,1'b1,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h66};
        vec[14] = '{1'b1,1'b1,1'b0,1'b0,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h66};
        vec[15] = '{1'b1,1'b1,1'b1,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b0,8'hA5,8'h66};
        vec[16] = '{1'b1,1'b0,1'b1,1'b1,8'h0E,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b1,8'hA5,8'h0E};
        vec[17] = '{1'b1,1'b1,1'b0,1'b1,8'h5A,1'b0,8'hBF,  1'b1,8'hBF,1'b1,1'b0,1'b1,8'h5A,8'h5A};
        vec[18] = '{1'b1,1'b1,1'b0,1'b1,8'h66,1'b0,8'hBF,  1'b1,8'hBF,1'b1,1'b0,1'b1,8'h5A,8'h66};
        vec[19] = '{1'b1,1'b1,1'b0,1'b1,8'h66,1'b0,8'h40,  1'b0,8'hFF,1'b0,1'b0,1'b1,8'h5A,8'h66};
        vec[20] = '{1'b1,1'b1,1'b1,1'b1,8'h66,1'b0,8'h00,  1'b0,8'hFF,1'b0,1'b0,1'b1,8'h5A,8'h66};

        for (int i = 0; i < 21; i++) begin
            drive(vec[i].rst, vec[i].ld, vec[i].wr, vec[i].rd, vec[i].bus, vec[i].rel, vec[i].rdy);
            tick();
            chk($sformatf("v%0d cpu_wait", i),  32'(cpu_wait),  32'(vec[i].e_wait));
            chk($sformatf("v%0d dev_sel_n", i), 32'(dev_sel_n), 32'(vec[i].e_sel));
            chk($sformatf("v%0d dev_wr", i),    32'(dev_wr),    32'(vec[i].e_wr));
            chk($sformatf("v%0d dev_rd", i),    32'(dev_rd),    32'(vec[i].e_rd));
            chk($sformatf("v%0d dev_rs", i),    32'(dev_rs),    32'(vec[i].e_rs));
            chk($sformatf("v%0d dev_wdata", i), 32'(dev_wdata), 32'(vec[i].e_wdata));
            chk($sformatf("v%0d main_bus", i),  32'(main_bus),  32'(vec[i].e_bus));
        end
        // Both strobes low earlier in the table is a protocol error.
        chk("protocol err", 32'(dut.err_q), 32'd1);

        // Read timeout on device 5: reset first so err starts clear.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00);
        tick();
        tick();
        chk("rst err", 32'(dut.err_q), 32'd0);
        chk("rst wdata", 32'(dev_wdata), 32'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        tick();
        chk("to accept rd", 32'(dev_rd), 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k < 15) begin
                chk($sformatf("to k%0d dev_rd", k), 32'(dev_rd), 32'd1);
            end else begin
                chk("to done dev_rd", 32'(dev_rd),   32'd0);
                chk("to done wait",   32'(cpu_wait), 32'd0);
                chk("to done bus",    32'(main_bus), 32'hFF);
                chk("to done err",    32'(dut.err_q), 32'd1);
            end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00);
        tick();
        chk("to release bus", 32'(main_bus), 32'h66);

`ifdef IO_HUB_STATUS_EN
        // Status register read after the timeout: err set, then cleared.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        tick();
        chk("st sel", 32'(dev_sel_n), 32'hFF);
        chk("st rd",  32'(dev_rd),    32'd0);
        tick();
        chk("st err bit", 32'(main_bus[7]),   32'd1);
        chk("st addr",    32'(main_bus[2:0]), 32'd7);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        tick();
        tick();
        chk("st err clr", 32'(main_bus[7]), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00);
        tick();
`endif

        // Reset during RD_BUSY with no acknowledge.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h0D, 1'b0, 8'h00);
        tick();
        chk("mr rs", 32'(dev_rs), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 8'h00);
        tick();
        chk("mr busy sel", 32'(dev_sel_n), 32'hDF);
        chk("mr busy rd",  32'(dev_rd),    32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00);
        tick();
        chk("mr sel",  32'(dev_sel_n), 32'hFF);
        chk("mr rd",   32'(dev_rd),    32'd0);
        chk("mr wait", 32'(cpu_wait),  32'd0);
        chk("mr rs0",  32'(dev_rs),    32'd0);
        chk("mr err",  32'(dut.err_q), 32'd0);
        chk("mr bus",  32'(main_bus),  32'h66);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
